// File: rtl/qsg_pkg.sv
// Shared types and constants for the quadrature step generator.
package qsg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        FINISH = 2'd2
    } qsg_state_t;

    // {a,b} for each value of pos[1:0]
    localparam logic [1:0] PHASE_AB_00 = 2'b00;
    localparam logic [1:0] PHASE_AB_01 = 2'b10;
    localparam logic [1:0] PHASE_AB_10 = 2'b11;
    localparam logic [1:0] PHASE_AB_11 = 2'b01;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic logic [1:0] phase_ab(input logic [1:0] p);
        case (p)
            2'b00:   return PHASE_AB_00;
            2'b01:   return PHASE_AB_01;
            2'b10:   return PHASE_AB_10;
            default: return PHASE_AB_11;
        endcase
    endfunction

endpackage

// File: rtl/qsg_prescaler.sv
// Step-rate prescaler: counts down from div, ticks at zero while enabled.
module qsg_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             reload,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] r_count;

    assign tick = enable && (r_count == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (reload) begin
            r_count <= div;
        end else if (enable) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/quad_step_generator.sv
// Quadrature A/B step generator walking pos toward a loaded target.
// Optional index output z enabled by defining QSG_INDEX_EN.
module quad_step_generator
    import qsg_pkg::*;
#(
    parameter int N     = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             load,
    input  logic [N-1:0]     target,
    input  logic [DIV_W-1:0] div,
    output logic             a,
    output logic             b,
    output logic [N-1:0]     pos,
    output logic             dir,
    output logic             busy,
`ifdef QSG_INDEX_EN
    output logic             z,
`endif
    output logic             done
);

    localparam logic [N-1:0] POS_ONE = N'(1);

    qsg_state_t   r_state;
    logic [N-1:0] r_pos;
    logic [N-1:0] r_target;
    logic [N-1:0] r_pend_target;
    logic         r_pend;
    logic         r_dir;
    logic         r_busy;
    logic         r_done;
    logic         r_a;
    logic         r_b;

    logic         w_tick;
    logic         w_presc_en;
    logic         w_reload;
    logic         w_eff_load;
    logic [N-1:0] w_eff_target;
    logic [N-1:0] w_step_pos;
    logic [N-1:0] w_pos_next;

    assign w_presc_en   = enable && (r_state == MOVE);
    // A load that arrived during FINISH is replayed in the following IDLE cycle
    assign w_eff_load   = load || r_pend;
    assign w_eff_target = load ? target : r_pend_target;
    assign w_reload     = w_tick ||
                          ((r_state == IDLE) && w_eff_load && (w_eff_target != r_pos));
    assign w_step_pos   = (r_dir == DIR_UP) ? (r_pos + POS_ONE) : (r_pos - POS_ONE);
    assign w_pos_next   = w_tick ? w_step_pos : r_pos;

    qsg_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (w_presc_en),
        .reload  (w_reload),
        .div     (div),
        .tick    (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_pos         <= '0;
            r_target      <= '0;
            r_pend_target <= '0;
            r_pend        <= 1'b0;
            r_dir         <= DIR_DOWN;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_a           <= 1'b0;
            r_b           <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_pend <= 1'b0;
                    if (w_eff_load) begin
                        r_target <= w_eff_target;
                        if (w_eff_target == r_pos) begin
                            r_state <= FINISH;
                        end else begin
                            r_dir   <= (w_eff_target > r_pos) ? DIR_UP : DIR_DOWN;
                            r_busy  <= 1'b1;
                            r_state <= MOVE;
                        end
                    end
                end
                MOVE: begin
                    r_pos        <= w_pos_next;
                    {r_a, r_b}   <= phase_ab(w_pos_next[1:0]);
                    // Retarget decisions use the post-step position
                    if (load) begin
                        r_target <= target;
                        if (target == w_pos_next) begin
                            r_state <= FINISH;
                        end else begin
                            r_dir <= (target > w_pos_next) ? DIR_UP : DIR_DOWN;
                        end
                    end else if (w_tick && (w_pos_next == r_target)) begin
                        r_state <= FINISH;
                    end
                end
                FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                    if (load) begin
                        r_pend        <= 1'b1;
                        r_pend_target <= target;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef QSG_INDEX_EN
    logic r_z;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_z <= 1'b0;
        end else begin
            r_z <= (w_pos_next == '0);
        end
    end

    assign z = r_z;
`endif

    assign a    = r_a;
    assign b    = r_b;
    assign pos  = r_pos;
    assign dir  = r_dir;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_quad_step_generator.sv
// Self-checking bench for quad_step_generator: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural position/step model.
module tb_quad_step_generator;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       load;
    logic [7:0] target;
    logic [7:0] div;
    logic       a, b, dir, busy, done;
    logic [7:0] pos;
`ifdef QSG_INDEX_EN
    logic       z;
`endif

    int total = 0;
    int bad   = 0;

    quad_step_generator #(.N(8), .DIV_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .load    (load),
        .target  (target),
        .div     (div),
        .a       (a),
        .b       (b),
        .pos     (pos),
        .dir     (dir),
        .busy    (busy),
`ifdef QSG_INDEX_EN
        .z       (z),
`endif
        .done    (done)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 = idle, 1 = moving, 2 = reporting completion
    int         m_mode;
    int         m_wait;      // enabled cycles remaining before the next step
    logic [7:0] m_pos, m_tgt, m_pend_t;
    logic       m_dir, m_busy, m_done, m_pend, m_z;
    int         done_cnt;

    task automatic model_reset();
        m_mode = 0; m_wait = 0; m_pos = 0; m_tgt = 0; m_pend_t = 0;
        m_dir = 0; m_busy = 0; m_done = 0; m_pend = 0; m_z = 0;
    endtask

    task automatic model_edge(input logic en, input logic ld, input logic [7:0] tg,
                              input logic [7:0] dv);
        logic       eff_ld;
        logic [7:0] eff_t;
        logic       stepped;
        m_done = 0;
        if (m_mode == 2) begin
            m_done = 1; m_busy = 0; m_mode = 0;
            if (ld) begin m_pend = 1; m_pend_t = tg; end
        end else if (m_mode == 0) begin
            eff_ld = ld | m_pend;
            eff_t  = ld ? tg : m_pend_t;
            m_pend = 0;
            if (eff_ld) begin
                m_tgt = eff_t;
                if (eff_t == m_pos) m_mode = 2;
                else begin
                    m_dir = (int'(eff_t) > int'(m_pos));
                    m_wait = int'(dv); m_busy = 1; m_mode = 1;
                end
            end
        end else begin
            stepped = 0;
            if (en) begin
                if (m_wait == 0) begin
                    m_pos = m_dir ? m_pos + 8'd1 : m_pos - 8'd1;
                    m_wait = int'(dv); stepped = 1;
                end else m_wait--;
            end
            if (ld) begin
                m_tgt = tg;
                if (tg == m_pos) m_mode = 2;
                else m_dir = (int'(tg) > int'(m_pos));
            end else if (stepped && m_pos == m_tgt) m_mode = 2;
        end
        m_z = (m_pos == 8'd0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_pos"}, 32'(pos), 32'(m_pos));
        // Gray decode of the low two position bits gives the A/B phase
        chk({tag, "_ab"}, 32'({a, b}), 32'({m_pos[1] ^ m_pos[0], m_pos[1]}));
        chk({tag, "_busy"}, 32'(busy), 32'(m_busy));
        chk({tag, "_done"}, 32'(done), 32'(m_done));
        if (m_busy) chk({tag, "_dir"}, 32'(dir), 32'(m_dir));
`ifdef QSG_INDEX_EN
        chk({tag, "_z"}, 32'(z), 32'(m_z));
`endif
    endtask

    task automatic cyc(input string tag, input logic en, input logic ld,
                       input logic [7:0] tg, input logic [7:0] dv);
        enable = en; load = ld; target = tg; div = dv;
        @(posedge clk);
        model_edge(en, ld, tg, dv);
        #1;
        if (done) done_cnt++;
        check_all(tag);
        load = 1'b0;
        $display("cyc %s en=%0b ld=%0b tgt=%0d div=%0d -> pos=%0d ab=%0b%0b dir=%0b busy=%0b done=%0b",
                 tag, en, ld, tg, dv, pos, a, b, dir, busy, done);
    endtask

    task automatic settle(input string tag, input logic [7:0] dv);
        for (int i = 0; i < 600 && (m_mode != 0 || m_pend); i++) cyc(tag, 1'b1, 1'b0, 8'd0, dv);
        chk({tag, "_settled"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; load = 1'b0; target = 8'd0; div = 8'd0;
        done_cnt = 0;
        model_reset();
        #12;
        check_all("reset");
        reset_n = 1'b1;

        // Up move to 5 with div=3: steps every 4 cycles, done one cycle after the last
        cyc("t1_load", 1'b1, 1'b1, 8'd5, 8'd3);
        done_cnt = 0;
        for (int k = 1; k <= 22; k++) begin
            cyc("t1", 1'b1, 1'b0, 8'd0, 8'd3);
            if (k == 3)  chk("t1_pos3", 32'(pos), 32'd0);
            if (k == 4)  chk("t1_ab4", 32'({a, b}), 32'b10);
            if (k == 8)  chk("t1_ab8", 32'({a, b}), 32'b11);
            if (k == 20) chk("t1_pos20", 32'(pos), 32'd5);
            if (k == 21) chk("t1_done21", 32'(done), 32'd1);
            if (k == 21) chk("t1_busy21", 32'(busy), 32'd0);
        end
        chk("t1_done_once", 32'(done_cnt), 32'd1);

        // Down move to 2 with div=0: three back-to-back steps
        cyc("t2_load", 1'b1, 1'b1, 8'd2, 8'd0);
        for (int k = 1; k <= 5; k++) begin
            cyc("t2", 1'b1, 1'b0, 8'd0, 8'd0);
            if (k == 1) chk("t2_ab1", 32'({a, b}), 32'b00);
            if (k == 2) chk("t2_ab2", 32'({a, b}), 32'b01);
            if (k == 3) chk("t2_ab3", 32'({a, b}), 32'b11);
            if (k == 3) chk("t2_dir", 32'(dir), 32'd0);
            if (k == 4) chk("t2_done4", 32'(done), 32'd1);
        end

        // Target equal to pos: no step, busy never rises, done next cycle
        cyc("t3_load", 1'b1, 1'b1, 8'd2, 8'd0);
        chk("t3_busy", 32'(busy), 32'd0);
        cyc("t3", 1'b1, 1'b0, 8'd0, 8'd0);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_pos", 32'(pos), 32'd2);
        cyc("t3", 1'b1, 1'b0, 8'd0, 8'd0);

        // Return to 0, then move toward 10 with an enable gap at pos 3 and a retarget at pos 4
        cyc("t4_home", 1'b1, 1'b1, 8'd0, 8'd0);
        settle("t4_home", 8'd0);
        chk("t4_at0", 32'(pos), 32'd0);
        cyc("t4_load", 1'b1, 1'b1, 8'd10, 8'd1);
        for (int i = 0; i < 40 && m_pos != 8'd3; i++) cyc("t4_run", 1'b1, 1'b0, 8'd0, 8'd1);
        chk("t4_reach3", 32'(pos), 32'd3);
        for (int i = 0; i < 7; i++) cyc("t4_hold", 1'b0, 1'b0, 8'd0, 8'd1);
        chk("t4_held", 32'(pos), 32'd3);
        for (int i = 0; i < 40 && m_pos != 8'd4; i++) cyc("t4_run", 1'b1, 1'b0, 8'd0, 8'd1);
        chk("t4_reach4", 32'(pos), 32'd4);
        done_cnt = 0;
        cyc("t4_retgt", 1'b1, 1'b1, 8'd1, 8'd1);
        chk("t4_dirflip", 32'(dir), 32'd0);
        settle("t4_tail", 8'd1);
        chk("t4_final", 32'(pos), 32'd1);
        chk("t4_done_once", 32'(done_cnt), 32'd1);

        // Random traffic: loads in every state, enable gaps, varying div
        for (int i = 0; i < 500; i++) begin
            logic       en, ld;
            logic [7:0] tg, dv;
            en = ($urandom % 6) != 0;
            ld = ($urandom % 10) == 0;
            tg = ($urandom % 8 == 0) ? 8'($urandom) : 8'($urandom_range(0, 24));
            dv = 8'($urandom % 4);
            cyc("rnd", en, ld, tg, dv);
        end
        settle("rnd_end", 8'd0);

        // Reset in the middle of a move clears everything without a done pulse
        cyc("t5_load", 1'b1, 1'b1, 8'd40, 8'd2);
        for (int i = 0; i < 10; i++) cyc("t5_run", 1'b1, 1'b0, 8'd0, 8'd2);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all("t5_async");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc("t5_after", 1'b1, 1'b0, 8'd0, 8'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
